// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and datapath-side signals of the lock supervisor.
// master: the supervisor (drives the PLL reset and status, consumes locked).
// slave:  the surrounding logic (drives locked, observes reset and status).
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       timeout_err;
  logic [7:0] relock_count;
  logic       fault;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst_n,
    output ready,
    output timeout_err,
    output relock_count,
    output fault
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst_n,
    input  ready,
    input  timeout_err,
    input  relock_count,
    input  fault
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset and lock supervisor, clocked by the reference clock.
// It resets the PLL, waits for a synchronized lock, requires lock to hold
// for LOCK_STABLE_CYCLES, then releases the datapath reset.
// Optional feature: define PLL_SUP_RETRY_LIMIT_EN to stop in FAULT after
// MAX_RETRIES consecutive lock timeouts; otherwise timeouts retry forever.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RESET_PLL | pll_rst held high for POR_CYCLES
// WAIT_LOCK | PLL released, waiting for locked_s (bounded by timeout)
// STABILIZE | locked_s seen, must hold LOCK_STABLE_CYCLES before release
// RUN       | datapath out of reset, ready high
// FAULT     | retry limit reached; PLL held in reset until rst_n
module pll_lock_supervisor #(
  parameter int POR_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 4
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  pll_lock_supervisor_if.master  bus
);

  localparam int MAX_PS  = (POR_CYCLES > LOCK_STABLE_CYCLES) ? POR_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_PS > LOCK_TIMEOUT_CYCLES) ? MAX_PS : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  localparam logic [2:0] RESET_PLL = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABILIZE = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;

  if (POR_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 2 || MAX_RETRIES < 1)
  begin : g_param_check
    $error("pll_lock_supervisor: parameter out of range");
  end

  logic [1:0]       sync_q, sync_d;
  logic             locked_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [7:0]       relock_q, relock_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             timeout_hit;

`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam logic [2:0] FAULT = 3'd4;
  localparam int RTRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
  localparam logic [RTRY_W-1:0] RETRY_LAST = RTRY_W'(MAX_RETRIES - 1);
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic              fault_q, fault_d;
`endif

  // Two-flop synchronizer; the FSM only ever looks at its output.
  assign sync_d   = {sync_q[0], bus.pll_locked};
  assign locked_s = sync_q[1];

  // Next-state, counters and sticky status.
  always_comb begin
    state_d       = state_q;
    timeout_err_d = timeout_err_q;
    relock_d      = relock_q;
    timeout_hit   = 1'b0;
    case (state_q)
      RESET_PLL: if (cnt_q == POR_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        // Lock has priority over a timeout landing on the same cycle.
        if (locked_s) begin
          state_d = STABILIZE;
        end else if (cnt_q == TO_LAST) begin
          state_d       = RESET_PLL;
          timeout_err_d = 1'b1;
          timeout_hit   = 1'b1;
        end
      end
      STABILIZE: begin
        if (!locked_s)                  state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)  state_d = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_d = RESET_PLL;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end
      end
`ifdef PLL_SUP_RETRY_LIMIT_EN
      FAULT:   state_d = FAULT;
`endif
      default: state_d = RESET_PLL;
    endcase

`ifdef PLL_SUP_RETRY_LIMIT_EN
    retry_d = retry_q;
    if (timeout_hit) begin
      if (retry_q == RETRY_LAST) state_d = FAULT;
      else                       retry_d = retry_q + RTRY_W'(1);
    end
    if (state_d == STABILIZE && state_q != STABILIZE) retry_d = '0;
    fault_d = (state_d == FAULT);
`endif

    // Counter restarts on every transition and idles in RUN.
    if (state_d != state_q || state_q == RUN) cnt_d = '0;
    else                                      cnt_d = cnt_q + CNT_W'(1);

`ifdef PLL_SUP_RETRY_LIMIT_EN
    pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
`else
    pll_rst_d = (state_d == RESET_PLL);
`endif
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync_q        <= 2'b00;
      state_q       <= RESET_PLL;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      relock_q      <= 8'd0;
      pll_rst_q     <= 1'b1;
      sys_rst_n_q   <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      relock_q      <= relock_d;
      pll_rst_q     <= pll_rst_d;
      sys_rst_n_q   <= sys_rst_n_d;
      ready_q       <= ready_d;
    end
  end

`ifdef PLL_SUP_RETRY_LIMIT_EN
  // Consecutive-timeout counter and fault flag.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      retry_q <= '0;
      fault_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
      fault_q <= fault_d;
    end
  end
  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.pll_rst      = pll_rst_q;
  assign bus.sys_rst_n    = sys_rst_n_q;
  assign bus.ready        = ready_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with POR=4, STABLE=8, TIMEOUT=32.
// Inputs change and outputs are sampled on the falling edge of refclk.
module tb_pll_lock_supervisor;

  logic refclk;
  logic rst_n;
  int   checks;
  int   errors;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .POR_CYCLES          (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (4)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Reset values and release timing of the first pll_rst pulse.
  task automatic test_reset();
    rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    step(3);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b want 1", bus.pll_rst); end
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n: got %b want 0", bus.sys_rst_n); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
    checks++; if (bus.relock_count !== 8'd0) begin errors++; $display("FAIL reset_relock: got %0d want 0", bus.relock_count); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
    rst_n = 1'b1;
    step(3);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL release_pll_rst_3: got %b want 1", bus.pll_rst); end
    step(1);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL release_pll_rst_4: got %b want 0", bus.pll_rst); end
  endtask

  // Lock raised on the first WAIT_LOCK cycle: ready exactly 11 edges later.
  task automatic test_clean_lock();
    bus.pll_locked = 1'b1;
    step(10);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL clean_ready_10: got %b want 0", bus.ready); end
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL clean_sys_rst_n_10: got %b want 0", bus.sys_rst_n); end
    step(1);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL clean_ready_11: got %b want 1", bus.ready); end
    checks++; if (bus.sys_rst_n !== 1'b1) begin errors++; $display("FAIL clean_sys_rst_n_11: got %b want 1", bus.sys_rst_n); end
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL clean_pll_rst: got %b want 0", bus.pll_rst); end
  endtask

  // Short lock pulse falls back to WAIT_LOCK without resetting the PLL.
  task automatic test_glitch();
    int rst_seen;
    rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(4);
    rst_seen = 0;
    bus.pll_locked = 1'b1;
    for (int i = 0; i < 5; i++) begin step(1); if (bus.pll_rst) rst_seen++; end
    bus.pll_locked = 1'b0;
    for (int i = 0; i < 3; i++) begin step(1); if (bus.pll_rst) rst_seen++; end
    bus.pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin step(1); if (bus.pll_rst) rst_seen++; end
    checks++; if (rst_seen !== 0) begin errors++; $display("FAIL glitch_pll_rst: got %0d high cycles want 0", rst_seen); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL glitch_ready_10: got %b want 0", bus.ready); end
    step(1);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL glitch_ready_11: got %b want 1", bus.ready); end
    checks++; if (bus.relock_count !== 8'd0) begin errors++; $display("FAIL glitch_relock: got %0d want 0", bus.relock_count); end
  endtask

  // Lock loss in RUN, then repeated losses up to saturation.
  task automatic test_lock_loss();
    bus.pll_locked = 1'b0;
    step(2);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL loss_ready_2: got %b want 1", bus.ready); end
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL loss_pll_rst_2: got %b want 0", bus.pll_rst); end
    step(1);
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL loss_sys_rst_n_3: got %b want 0", bus.sys_rst_n); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL loss_ready_3: got %b want 0", bus.ready); end
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL loss_pll_rst_3: got %b want 1", bus.pll_rst); end
    checks++; if (bus.relock_count !== 8'd1) begin errors++; $display("FAIL loss_relock_1: got %0d want 1", bus.relock_count); end
    step(3);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL loss_pll_rst_6: got %b want 1", bus.pll_rst); end
    step(1);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL loss_pll_rst_7: got %b want 0", bus.pll_rst); end
    bus.pll_locked = 1'b1;
    step(11);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL loss_relock_ready: got %b want 1", bus.ready); end
  endtask

  task automatic test_relock_saturation();
    for (int n = 2; n <= 300; n++) begin
      bus.pll_locked = 1'b0;
      step(7);
      if (n == 254) begin
        checks++; if (bus.relock_count !== 8'd254) begin errors++; $display("FAIL sat_relock_254: got %0d want 254", bus.relock_count); end
      end
      if (n == 255) begin
        checks++; if (bus.relock_count !== 8'd255) begin errors++; $display("FAIL sat_relock_255: got %0d want 255", bus.relock_count); end
      end
      bus.pll_locked = 1'b1;
      step(11);
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL sat_ready iter %0d: got %b want 1", n, bus.ready); end
    end
    checks++; if (bus.relock_count !== 8'd255) begin errors++; $display("FAIL sat_relock_300: got %0d want 255", bus.relock_count); end
  endtask

  // Lock never arrives: timeouts every 36 cycles; optional FAULT on the 4th.
  task automatic test_timeout();
    bus.pll_locked = 1'b0;
    step(3);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_pll_rst_t0: got %b want 1", bus.pll_rst); end
    step(35);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL to_pll_rst_35: got %b want 0", bus.pll_rst); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_35: got %b want 0", bus.timeout_err); end
    step(1);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_pll_rst_36: got %b want 1", bus.pll_rst); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_36: got %b want 1", bus.timeout_err); end
    step(35);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL to_pll_rst_71: got %b want 0", bus.pll_rst); end
    step(1);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_pll_rst_72: got %b want 1", bus.pll_rst); end
    step(72);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_pll_rst_144: got %b want 1", bus.pll_rst); end
    step(4);
`ifdef PLL_SUP_RETRY_LIMIT_EN
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_fault_pll_rst: got %b want 1", bus.pll_rst); end
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL to_fault: got %b want 1", bus.fault); end
`else
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL to_pll_rst_148: got %b want 0", bus.pll_rst); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL to_fault: got %b want 0", bus.fault); end
`endif
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", bus.timeout_err); end
  endtask

  // Build up non-zero status, then reset for one cycle while in STABILIZE.
  task automatic test_reset_mid_stabilize();
    rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(4);
    bus.pll_locked = 1'b1;
    step(11);
    bus.pll_locked = 1'b0;
    step(7);
    step(32);
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL mid_pre_err: got %b want 1", bus.timeout_err); end
    checks++; if (bus.relock_count !== 8'd1) begin errors++; $display("FAIL mid_pre_relock: got %0d want 1", bus.relock_count); end
    step(4);
    bus.pll_locked = 1'b1;
    step(5);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL mid_pre_pll_rst: got %b want 0", bus.pll_rst); end
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL mid_pll_rst: got %b want 1", bus.pll_rst); end
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL mid_sys_rst_n: got %b want 0", bus.sys_rst_n); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", bus.timeout_err); end
    checks++; if (bus.relock_count !== 8'd0) begin errors++; $display("FAIL mid_relock: got %0d want 0", bus.relock_count); end
    step(3);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL mid_release_3: got %b want 1", bus.pll_rst); end
    step(1);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL mid_release_4: got %b want 0", bus.pll_rst); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    test_reset();
    test_clean_lock();
    test_glitch();
    test_lock_loss();
    test_relock_saturation();
    test_timeout();
    test_reset_mid_stabilize();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Reset and lock supervisor for the 250/50 MHz PLL wrapper. Sits directly around the PLL in the clocking subsystem:
- drives the PLL's active-high `rst`;
- consumes its asynchronous `locked` output;
- releases a clean system reset to the online-arithmetic datapath only after lock has been continuously stable.

It runs on the 125 MHz reference clock, so it stays alive whenever the PLL outputs are absent.

## Interface
Parameters:
- `POR_CYCLES`, 16, number of cycles `pll_rst` is held high per PLL reset attempt (≥1).
- `LOCK_STABLE_CYCLES`, 1024, consecutive synchronized-locked cycles required before system reset release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536, maximum cycles in WAIT_LOCK before the PLL is reset again (≥2).
- `MAX_RETRIES`, 4, consecutive timeouts before FAULT. Used only with `PLL_SUP_RETRY_LIMIT_EN`.

Ports:
- `refclk`  in  1  125 MHz reference clock; the only clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `pll_locked`  in  1  PLL `locked`; asynchronous to `refclk`.
- `pll_rst`  out  1  PLL reset; active-high, registered.
- `sys_rst_n`  out  1  downstream datapath reset; active-low, registered.
- `ready`  out  1  high exactly while in RUN.
- `timeout_err`  out  1  sticky; set on any lock timeout, cleared only by `rst_n`.
- `relock_count`  out  8  count of lock losses seen in RUN; saturates at 255.
- `fault`  out  1  high in FAULT; constant 0 when the macro is not defined.

## Operation
Lock synchronization:
- `pll_locked` passes through a 2-FF synchronizer to produce `locked_s`.
- The FSM uses only `locked_s`.

Cycle counter:
- One shared counter, width `$clog2(max(POR_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES))`.
- Cleared on every state change.

Reset:
- Applies while `rst_n`=0 at an edge; overrides everything, including mid-operation.
- Sets state RESET_PLL, counter 0, synchronizer FFs 0, retry counter 0.
- Output values: `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `timeout_err`=0, `relock_count`=0, `fault`=0.

States:
- **RESET_PLL**: `pll_rst`=1, `sys_rst_n`=0.
  - When counter==`POR_CYCLES`-1 → WAIT_LOCK.
- **WAIT_LOCK**: `pll_rst`=0, `sys_rst_n`=0.
  - `locked_s`=1 → STABILIZE.
  - Otherwise, when counter==`LOCK_TIMEOUT_CYCLES`-1 → RESET_PLL and set `timeout_err`.
- **STABILIZE**: `pll_rst`=0, `sys_rst_n`=0.
  - `locked_s`=0 → WAIT_LOCK. This is a glitch: no PLL reset and no `relock_count` increment.
  - When counter==`LOCK_STABLE_CYCLES`-1 with `locked_s`=1 → RUN.
  - Entering STABILIZE clears the retry counter.
- **RUN**: `sys_rst_n`=1, `ready`=1.
  - `locked_s`=0 → RESET_PLL with `sys_rst_n`=0 on the same edge; `relock_count` increments, saturating.

Simultaneous events:
- In WAIT_LOCK, if `locked_s` rises on the timeout cycle, lock wins: go to STABILIZE with no timeout flagged.

## Timing
- All outputs are registered and decoded from the state register; there are no combinational input-to-output paths.
- `pll_rst` pulse width: exactly `POR_CYCLES` cycles per attempt.
- Lock acquired: `pll_locked` rises before edge e1 → `sys_rst_n`/`ready` high after edge e(3+`LOCK_STABLE_CYCLES`), provided the signal stays high.
- Lock lost in RUN: `pll_locked` falls before edge e1 → `sys_rst_n`=0, `ready`=0, `pll_rst`=1 after edge e3.
- Timeout: with `pll_locked` held low, `pll_rst` re-asserts `LOCK_TIMEOUT_CYCLES` cycles after WAIT_LOCK entry. The period is `POR_CYCLES`+`LOCK_TIMEOUT_CYCLES`.
- Release after reset: after `rst_n` returns high, the first `pll_rst` pulse lasts `POR_CYCLES` cycles counted from the first edge with `rst_n`=1.

## Configuration
- Macro: `PLL_SUP_RETRY_LIMIT_EN`.
- Defined:
  - An internal counter of consecutive timeouts is kept.
  - When the `MAX_RETRIES`-th consecutive timeout occurs, the FSM enters FAULT instead of RESET_PLL.
  - In FAULT: `pll_rst`=1, `sys_rst_n`=0, `fault`=1. The only exit is `rst_n`.
- Undefined:
  - Timeouts retry forever.
  - FAULT state and retry counter are not synthesized; `fault` is tied to 0.

## Test plan
All scenarios use `POR_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32.
- Reset values: hold `rst_n`=0 for 3 cycles → `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `relock_count`=0, `timeout_err`=0. After release, `pll_rst` falls after exactly 4 cycles.
- Clean lock: raise `pll_locked` on the first WAIT_LOCK cycle and hold → `sys_rst_n`=1 and `ready`=1 exactly 11 edges later.
- Glitch: pulse `pll_locked` high for 5 cycles, then hold high → no `pll_rst` re-assertion, `relock_count`=0. `ready` asserts 11 edges after the second rise.
- Lock loss: drop `pll_locked` in RUN → 3 edges later `sys_rst_n`=0 and `pll_rst`=1 for 4 cycles, `relock_count`=1. Repeat 300 times → `relock_count`=255.
- Timeout: keep `pll_locked`=0 → `pll_rst` pulses repeat every 36 cycles and `timeout_err`=1 after the first timeout. With macro defined and `MAX_RETRIES`=4 → `fault`=1 after the 4th timeout, with `pll_rst` held at 1.
- Reset mid-STABILIZE: assert `rst_n`=0 for 1 cycle → state RESET_PLL, `timeout_err` and `relock_count` cleared.
